// File: rtl/datapath_sequencer_pkg.sv
// Shared types and constants for the datapath sequencer: opcodes, FSM states
// and operand-mux select encodings.
package datapath_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_LDI = 4'h2,
    OP_LD  = 4'h3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    MEM_WAIT  = 2'd2,
    WRITEBACK = 2'd3
  } seq_state_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_IMM = 2'b10;

  localparam int unsigned OPCODE_WIDTH = 4;

endpackage

// File: rtl/datapath_sequencer_decoder.sv
// Combinational instruction decoder: splits an instruction word into its
// fields and classifies the opcode (legal / NOP / memory load / immediate).
module datapath_instr_decoder
  import datapath_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RF_ADDR_WIDTH = 2,
  parameter int unsigned INSTR_WIDTH   = OPCODE_WIDTH + 2 * RF_ADDR_WIDTH + DATA_WIDTH
) (
  input  logic [INSTR_WIDTH-1:0]   instr_i,
  output logic [RF_ADDR_WIDTH-1:0] rd_o,
  output logic [RF_ADDR_WIDTH-1:0] rs_o,
  output logic [DATA_WIDTH-1:0]    imm_o,
  output logic                     legal_o,
  output logic                     is_nop_o,
  output logic                     uses_mem_o,
  output logic                     uses_imm_o
);

  logic [OPCODE_WIDTH-1:0] opcode_s;

  assign opcode_s = instr_i[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign rd_o     = instr_i[INSTR_WIDTH-OPCODE_WIDTH-1 -: RF_ADDR_WIDTH];
  assign rs_o     = instr_i[DATA_WIDTH +: RF_ADDR_WIDTH];
  assign imm_o    = instr_i[DATA_WIDTH-1:0];

  always_comb begin
    legal_o    = 1'b0;
    is_nop_o   = 1'b0;
    uses_mem_o = 1'b0;
    uses_imm_o = 1'b0;
    case (opcode_e'(opcode_s))
      OP_NOP: begin
        legal_o  = 1'b1;
        is_nop_o = 1'b1;
      end
      OP_MOV: legal_o = 1'b1;
      OP_LDI: begin
        legal_o    = 1'b1;
        uses_imm_o = 1'b1;
      end
      OP_LD: begin
        legal_o    = 1'b1;
        uses_mem_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle register-transfer sequencer (IDLE/DECODE/MEM_WAIT/WRITEBACK).
// Optional load timeout is enabled by defining MEM_TIMEOUT_EN.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned RF_ADDR_WIDTH  = 2,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [OPCODE_WIDTH+2*RF_ADDR_WIDTH+DATA_WIDTH-1:0] instr,
  input  logic                                          instr_valid,
  output logic                                          instr_ready,
  output logic                                          mem_req,
  output logic [DATA_WIDTH-1:0]                         mem_addr,
  input  logic                                          mem_ack,
  output logic [1:0]                                    mux_select,
  output logic [DATA_WIDTH-1:0]                         imm_out,
  output logic [RF_ADDR_WIDTH-1:0]                      rf_raddr,
  output logic [RF_ADDR_WIDTH-1:0]                      rf_waddr,
  output logic                                          rf_we,
  output logic                                          done,
  output logic                                          illegal_op,
  output logic                                          mem_timeout,
  output logic [COUNT_WIDTH-1:0]                        retired_count
);

  localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + 2 * RF_ADDR_WIDTH + DATA_WIDTH;

  seq_state_e state_q, state_d;

  logic [RF_ADDR_WIDTH-1:0] dec_rd_s, dec_rs_s;
  logic [DATA_WIDTH-1:0]    dec_imm_s;
  logic dec_legal_s, dec_nop_s, dec_mem_s, dec_imm_sel_s;
  logic accept_s, to_hit_s;

  logic [RF_ADDR_WIDTH-1:0] rd_q, rs_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic legal_q, nop_q, ld_q, ldi_q;

  logic ready_q, mem_req_q, rf_we_q, done_q, illegal_q;
  logic [1:0] mux_q, mux_d;
  logic [COUNT_WIDTH-1:0] count_q;

  datapath_instr_decoder #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RF_ADDR_WIDTH(RF_ADDR_WIDTH),
    .INSTR_WIDTH  (INSTR_WIDTH)
  ) u_decoder (
    .instr_i   (instr),
    .rd_o      (dec_rd_s),
    .rs_o      (dec_rs_s),
    .imm_o     (dec_imm_s),
    .legal_o   (dec_legal_s),
    .is_nop_o  (dec_nop_s),
    .uses_mem_o(dec_mem_s),
    .uses_imm_o(dec_imm_sel_s)
  );

  assign accept_s = instr_valid & ready_q & (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = DECODE;
        else          state_d = IDLE;
      end
      DECODE: begin
        if (!legal_q || nop_q) state_d = IDLE;
        else if (ld_q)         state_d = MEM_WAIT;
        else                   state_d = WRITEBACK;
      end
      MEM_WAIT: begin
        // An ack in the same cycle as the timeout still completes the load.
        if (mem_ack)       state_d = WRITEBACK;
        else if (to_hit_s) state_d = IDLE;
        else               state_d = MEM_WAIT;
      end
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    mux_d = SEL_RF;
    if (state_d == WRITEBACK) begin
      if (ld_q)       mux_d = SEL_MEM;
      else if (ldi_q) mux_d = SEL_IMM;
      else            mux_d = SEL_RF;
    end else begin
      mux_d = SEL_RF;
    end
  end

  // Instruction fields stay on the outputs until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      legal_q <= 1'b0;
      nop_q   <= 1'b0;
      ld_q    <= 1'b0;
      ldi_q   <= 1'b0;
    end else if (accept_s) begin
      rd_q    <= dec_rd_s;
      rs_q    <= dec_rs_s;
      imm_q   <= dec_imm_s;
      legal_q <= dec_legal_s;
      nop_q   <= dec_nop_s;
      ld_q    <= dec_mem_s;
      ldi_q   <= dec_imm_sel_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q   <= 1'b0;
      mem_req_q <= 1'b0;
      rf_we_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mux_q     <= SEL_RF;
      count_q   <= '0;
    end else begin
      ready_q   <= (state_d == IDLE);
      mem_req_q <= (state_d == MEM_WAIT);
      rf_we_q   <= (state_d == WRITEBACK);
      done_q    <= (state_d == WRITEBACK);
      illegal_q <= accept_s & ~dec_legal_s;
      mux_q     <= mux_d;
      if ((state_q == WRITEBACK) || ((state_q == DECODE) && legal_q && nop_q)) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  // Counts MEM_WAIT cycles without an ack; hit on the last allowed one.
  assign to_hit_s = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == MEM_WAIT) & ~mem_ack & to_hit_s;
      if (state_q == DECODE) begin
        to_cnt_q <= '0;
      end else if ((state_q == MEM_WAIT) && !mem_ack) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign mem_timeout = timeout_q;
`else
  assign to_hit_s    = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  assign instr_ready   = ready_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = imm_q;
  assign mux_select    = mux_q;
  assign imm_out       = imm_q;
  assign rf_raddr      = rs_q;
  assign rf_waddr      = rd_q;
  assign rf_we         = rf_we_q;
  assign done          = done_q;
  assign illegal_op    = illegal_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed, table-driven bench for datapath_sequencer; multi-cycle loads,
// reset abort and (with MEM_TIMEOUT_EN) load timeout are hand sequences.
module tb_datapath_sequencer;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_CYC = 3;
`else
  localparam int unsigned TO_CYC = 15;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [1:0]  mux_select;
  logic [7:0]  imm_out;
  logic [1:0]  rf_raddr;
  logic [1:0]  rf_waddr;
  logic        rf_we;
  logic        done;
  logic        illegal_op;
  logic        mem_timeout;
  logic [15:0] retired_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;

  datapath_sequencer #(
    .DATA_WIDTH    (8),
    .RF_ADDR_WIDTH (2),
    .COUNT_WIDTH   (16),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mux_select   (mux_select),
    .imm_out      (imm_out),
    .rf_raddr     (rf_raddr),
    .rf_waddr     (rf_waddr),
    .rf_we        (rf_we),
    .done         (done),
    .illegal_op   (illegal_op),
    .mem_timeout  (mem_timeout),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    logic        ill;
    logic        we;
    logic [1:0]  mux;
    logic [1:0]  raddr;
    logic [1:0]  waddr;
    logic [7:0]  imm;
    logic        inc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            instr     ill   we    mux    rs     rd     imm    inc
    vecs[0] = '{16'h285A, 1'b0, 1'b1, 2'b10, 2'd0, 2'd2, 8'h5A, 1'b1}; // LDI r2,5A
    vecs[1] = '{16'h1700, 1'b0, 1'b1, 2'b00, 2'd3, 2'd1, 8'h00, 1'b1}; // MOV r1,r3
    vecs[2] = '{16'h7633, 1'b1, 1'b0, 2'b00, 2'd2, 2'd1, 8'h33, 1'b0}; // illegal 7
    vecs[3] = '{16'h0DC3, 1'b0, 1'b0, 2'b00, 2'd1, 2'd3, 8'hC3, 1'b1}; // NOP
    vecs[4] = '{16'h2EFF, 1'b0, 1'b1, 2'b10, 2'd2, 2'd3, 8'hFF, 1'b1}; // LDI r3,FF
    vecs[5] = '{16'hFFFF, 1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 8'hFF, 1'b0}; // illegal F
    vecs[6] = '{16'h1281, 1'b0, 1'b1, 2'b00, 2'd2, 2'd0, 8'h81, 1'b1}; // MOV r0,r2

    rst = 1'b1; instr = 16'h0000; instr_valid = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    chk("rst_ready", instr_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_mux", mux_select, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_count", retired_count, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", instr_ready, 1);

    // Table: each vector accepted in its cycle 0, back-to-back with the last.
    for (int i = 0; i < 7; i++) begin
      instr = vecs[i].instr; instr_valid = 1'b1;
      tick();
      chk("c1_ready", instr_ready, 0);
      chk("c1_illegal", illegal_op, vecs[i].ill);
      chk("c1_rf_we", rf_we, 0);
      chk("c1_mem_req", mem_req, 0);
      if (!vecs[i].we) instr_valid = 1'b0;
      tick();
      instr_valid = 1'b0;
      chk("c2_rf_we", rf_we, vecs[i].we);
      chk("c2_done", done, vecs[i].we);
      chk("c2_mux", mux_select, vecs[i].mux);
      chk("c2_raddr", rf_raddr, vecs[i].raddr);
      chk("c2_waddr", rf_waddr, vecs[i].waddr);
      chk("c2_imm", imm_out, vecs[i].imm);
      chk("c2_mem_addr", mem_addr, vecs[i].imm);
      chk("c2_ready", instr_ready, !vecs[i].we);
      chk("c2_illegal", illegal_op, 0);
      if (vecs[i].inc) exp_count++;
      tick();
      chk("c3_ready", instr_ready, 1);
      chk("c3_rf_we", rf_we, 0);
      chk("c3_count", retired_count, exp_count);
    end

`ifndef MEM_TIMEOUT_EN
    // LD r0,[10]; stray ack in DECODE, real ack in cycle 5.
    instr = 16'h3010; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ld_c1_mem_req", mem_req, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk("ld_mem_req", mem_req, 1);
      chk("ld_mem_addr", mem_addr, 8'h10);
      chk("ld_wait_rf_we", rf_we, 0);
      chk("ld_wait_ready", instr_ready, 0);
      chk("ld_no_timeout", mem_timeout, 0);
      if (c == 5) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("ld_c6_rf_we", rf_we, 1);
    chk("ld_c6_mux", mux_select, 2'b01);
    chk("ld_c6_waddr", rf_waddr, 0);
    chk("ld_c6_done", done, 1);
    chk("ld_c6_mem_req", mem_req, 0);
    exp_count++;
    tick();
    chk("ld_c7_ready", instr_ready, 1);
    chk("ld_c7_count", retired_count, exp_count);
`else
    // LD with no ack: aborted after three wait cycles.
    instr = 16'h3055; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    for (int c = 2; c <= 4; c++) begin
      chk("to_mem_req", mem_req, 1);
      chk("to_pending", mem_timeout, 0);
      tick();
    end
    chk("to_pulse", mem_timeout, 1);
    chk("to_mem_req_off", mem_req, 0);
    chk("to_rf_we", rf_we, 0);
    chk("to_ready", instr_ready, 1);
    tick();
    chk("to_pulse_end", mem_timeout, 0);
    chk("to_count", retired_count, exp_count);
    chk("to_rf_we2", rf_we, 0);
    // Ack on the third wait cycle wins over the timeout.
    instr = 16'h3255; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    for (int c = 2; c <= 4; c++) begin
      chk("ack3_mem_req", mem_req, 1);
      if (c == 4) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("ack3_rf_we", rf_we, 1);
    chk("ack3_mux", mux_select, 2'b01);
    chk("ack3_timeout", mem_timeout, 0);
    chk("ack3_done", done, 1);
    exp_count++;
    tick();
    chk("ack3_count", retired_count, exp_count);
    chk("ack3_ready", instr_ready, 1);
`endif

    // Reset during MEM_WAIT: load is abandoned and never written.
    instr = 16'h3120; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rw_c2_mem_req", mem_req, 1);
    tick();
    chk("rw_c3_mem_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    chk("rw_mem_req", mem_req, 0);
    chk("rw_ready", instr_ready, 0);
    chk("rw_rf_we", rf_we, 0);
    chk("rw_count", retired_count, exp_count);
    chk("rw_mem_addr", mem_addr, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rw_c5_ready", instr_ready, 1);
    chk("rw_c5_rf_we", rf_we, 0);
    chk("rw_c5_mem_req", mem_req, 0);
    tick();
    chk("rw_c6_rf_we", rf_we, 0);
    chk("rw_c6_count", retired_count, exp_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control FSM that executes one register-transfer instruction at a time. It drives the operand-source mux select (RF / memory / immediate), register-file read and write controls, and a single-outstanding memory read handshake. It sits between the instruction source and the datapath formed by the register file, data memory and the 3-input operand mux.

Parameters:
DATA_WIDTH, 8, width of the immediate/address field and of imm_out and mem_addr
RF_ADDR_WIDTH, 2, register-file address width
COUNT_WIDTH, 16, width of retired_count
TIMEOUT_CYCLES, 15, maximum MEM_WAIT cycles (used only with MEM_TIMEOUT_EN)
- Localparam INSTR_WIDTH = 4 + 2*RF_ADDR_WIDTH + DATA_WIDTH (16 at defaults).

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
instr  input  INSTR_WIDTH  instruction: opcode [MSB-:4], then rd, then rs, then imm/addr in the LSBs
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept an instruction
mem_req  output  1  memory read request, level
mem_addr  output  DATA_WIDTH  memory read address
mem_ack  input  1  memory read complete; read data is held stable by memory until the next mem_req
mux_select  output  2  operand mux select: 00 RF, 01 MEM, 10 IMM
imm_out  output  DATA_WIDTH  immediate operand to the mux
rf_raddr  output  RF_ADDR_WIDTH  RF read address (rs)
rf_waddr  output  RF_ADDR_WIDTH  RF write address (rd)
rf_we  output  1  RF write enable
done  output  1  1-cycle pulse when an instruction writes back
illegal_op  output  1  1-cycle pulse when an opcode is undefined
mem_timeout  output  1  1-cycle pulse when a load is aborted; tied 0 when MEM_TIMEOUT_EN is absent
retired_count  output  COUNT_WIDTH  number of retired instructions; wraps

Behaviour:
- Opcodes:
  - 0x0 NOP
  - 0x1 MOV rd<-RF[rs]
  - 0x2 LDI rd<-imm
  - 0x3 LD rd<-MEM[addr]
  - 0x4-0xF are illegal.
- States:
  - IDLE: instr_ready=1.
  - DECODE: one cycle.
  - MEM_WAIT: mem_req=1.
  - WRITEBACK: one cycle, rf_we=1, done=1.
- Transitions:
  - IDLE -> DECODE on instr_valid&instr_ready; the instruction fields are latched in that cycle.
  - DECODE -> WRITEBACK for MOV/LDI.
  - DECODE -> MEM_WAIT for LD.
  - DECODE -> IDLE for NOP and illegal.
  - MEM_WAIT -> WRITEBACK on mem_ack.
  - WRITEBACK -> IDLE.
- Output timing:
  - All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
  - mux_select is 01 only in WRITEBACK of LD and 10 only in WRITEBACK of LDI; it is 00 otherwise.
  - rf_raddr, rf_waddr, imm_out and mem_addr hold the latched fields from DECODE until the next accept.
- Latency, with accept in cycle 0:
  - MOV/LDI: rf_we in cycle 2, instr_ready again in cycle 3.
  - LD with mem_ack in cycle k (k>=2): rf_we in cycle k+1.
- retired_count:
  - Increments by 1 at the end of WRITEBACK.
  - Increments by 1 at the end of DECODE for NOP.
  - Illegal opcodes and timeouts do not count.
  - Wraps from all-ones to 0.
- illegal_op pulses in the DECODE cycle of an illegal opcode.
- Boundary conditions:
  - instr_valid while not in IDLE: ignored, because instr_ready=0.
  - mem_ack outside MEM_WAIT: ignored.
  - Back-to-back instructions: the next accept is possible in the cycle after WRITEBACK.
  - rst in any state: the next state is IDLE. On reset, mem_req, rf_we, done, illegal_op and mem_timeout go to 0, and the aborted instruction is never written.
  - Other reset values: instr_ready=0 during rst and 1 after it, mux_select=00, imm_out/mem_addr/rf_raddr/rf_waddr=0, retired_count=0.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - A counter is cleared on entry to MEM_WAIT and increments each cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES without an ack, the FSM goes to IDLE and mem_timeout pulses for 1 cycle.
  - There is no write and no count.
  - mem_ack arriving in the same cycle as the timeout wins, and the instruction writes back normally.
- Undefined: MEM_WAIT waits indefinitely, and mem_timeout is constant 0.

Decomposition:
- Package datapath_seq_pkg holds:
  - opcode_e enum (OP_NOP, OP_MOV, OP_LDI, OP_LD)
  - seq_state_e enum (IDLE, DECODE, MEM_WAIT, WRITEBACK)
  - mux select constants SEL_RF=2'b00, SEL_MEM=2'b01, SEL_IMM=2'b10
- One natural combinational sub-module: datapath_instr_decoder. It splits instr into fields and flags legal/uses_mem/uses_imm.

Test Plan:
- Reset, then instr=LDI rd=2 imm=0x5A with valid in cycle 0 -> cycle 2: rf_we=1, rf_waddr=2, mux_select=10, imm_out=0x5A, done=1; retired_count=1.
- MOV rd=1 rs=3 -> cycle 2: rf_we=1, mux_select=00, rf_raddr=3, rf_waddr=1; instr_valid held high throughout -> instr_ready=0 in cycles 1-2.
- LD rd=0 addr=0x10, mem_ack delayed 4 cycles -> mem_req=1 for exactly cycles 2-5, mem_addr=0x10, rf_we with mux_select=01 in cycle 6.
- Opcode 0x7 -> illegal_op pulse in cycle 1, no rf_we, retired_count unchanged, instr_ready=1 in cycle 2; NOP -> retired_count +1 with no rf_we.
- rst asserted during MEM_WAIT of LD -> next cycle: IDLE, mem_req=0, no rf_we ever, retired_count=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=3: LD with no ack -> mem_timeout pulse after 3 wait cycles, return to IDLE, no write; repeat with ack on the third cycle -> normal writeback.
